// File: rtl/max_pool_ctrl.sv
// Sequencer for the 2x2/stride-2 max-pool datapath: walks a W x H raster stream and
// drives buffer index, write enable and clear, and emits one pooled word per window.
module max_pool_ctrl #(
  parameter int HWORD        = 16,
  parameter int OUT_BUF_BITS = 5,
  parameter int DIM_BITS     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIM_BITS-1:0]     cfg_width,
  input  logic [DIM_BITS-1:0]     cfg_height,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_BUF_BITS-2:0] pool_idx,
  output logic                    pool_wen,
  output logic                    pool_clr_n,
  input  logic [HWORD-1:0]        pool_res,
  output logic                    out_valid,
  output logic [HWORD-1:0]        out_data,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int MAX_W = 1 << OUT_BUF_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_EVEN,
    S_ODD,
    S_SKIP,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [DIM_BITS-1:0] width, height;
  logic [DIM_BITS-1:0] row, col;
  logic                cfg_ok;
  logic                cfg_err_nxt;
  logic                last_col, last_row, pen_row, odd_tail;
  logic                accept;

  assign cfg_ok   = (cfg_width >= DIM_BITS'(2)) && (cfg_height >= DIM_BITS'(2)) &&
                    (int'(cfg_width) <= MAX_W);
  assign last_col = (col == width - DIM_BITS'(1));
  assign last_row = (row == height - DIM_BITS'(1));
  assign pen_row  = (row == height - DIM_BITS'(2));
  // The last pixel of an odd-width row has no partner column and is dropped
  assign odd_tail = last_col & width[0];
  assign accept   = in_valid & in_ready;

  assign pool_idx = col[OUT_BUF_BITS-1:1];
  assign out_data = pool_res;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      width   <= '0;
      height  <= '0;
      row     <= '0;
      col     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= cfg_err_nxt;
      if (state == S_IDLE && start && cfg_ok) begin
        width  <= cfg_width;
        height <= cfg_height;
        row    <= '0;
        col    <= '0;
      end else if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= row + DIM_BITS'(1);
        end else begin
          col <= col + DIM_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    pool_wen    = 1'b0;
    pool_clr_n  = 1'b1;
    out_valid   = 1'b0;
    done        = 1'b0;
    cfg_err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) state_nxt = S_CLEAR;
          else        cfg_err_nxt = 1'b1;
        end
      end
      S_CLEAR: begin
        pool_clr_n = 1'b0;
        state_nxt  = S_EVEN;
      end
      S_EVEN: begin
        in_ready = 1'b1;
        pool_wen = in_valid & ~odd_tail;
        if (in_valid && last_col) state_nxt = last_row ? S_DONE : S_ODD;
      end
      S_ODD: begin
        // Odd column of an odd row completes the window: emit straight from the datapath
        if (col[0]) begin
          in_ready  = out_ready;
          out_valid = in_valid;
        end else begin
          in_ready = 1'b1;
          pool_wen = in_valid & ~odd_tail;
        end
        if (in_valid && in_ready && last_col) begin
          if (last_row)                state_nxt = S_DONE;
          else if (height[0] && pen_row) state_nxt = S_SKIP;
          else                         state_nxt = S_CLEAR;
        end
      end
      S_SKIP: begin
        in_ready = 1'b1;
        if (in_valid && last_col) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Self-checking bench for max_pool_ctrl with a behavioural model of the pool datapath
// (signed max against a 16-entry buffer) closing the loop on pool_res.
module tb_max_pool_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_width = 8'd0;
  logic [7:0]  cfg_height = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  pool_idx;
  logic        pool_wen;
  logic        pool_clr_n;
  logic [15:0] pool_res;
  logic [15:0] req_data = 16'd0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int checks = 0;
  int fails  = 0;

  max_pool_ctrl #(.HWORD(16), .OUT_BUF_BITS(5), .DIM_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .pool_idx(pool_idx), .pool_wen(pool_wen),
    .pool_clr_n(pool_clr_n), .pool_res(pool_res), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Datapath model: buffer is deliberately untouched by rst
  logic signed [15:0] pbuf [16];
  always_comb pool_res = ($signed(req_data) > pbuf[pool_idx]) ? req_data : pbuf[pool_idx];
  always @(posedge clk) begin
    if (!pool_clr_n) begin
      for (int i = 0; i < 16; i++) pbuf[i] <= 16'sh8000;
    end else if (pool_wen) begin
      pbuf[pool_idx] <= pool_res;
    end
  end

  typedef struct {
    logic        st;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic [5:0]  flags;   // {in_ready, pool_wen, pool_clr_n, out_valid, busy, done}
    logic [3:0]  idx;
    logic [15:0] o;
  } vec_t;

  vec_t vecs [13];

  logic [15:0] stim [64];
  int          nStim;
  logic [15:0] outs [$];
  logic [15:0] expOut [$];
  int          accCnt, wenCnt, clrCnt, doneCnt;

  function automatic vec_t makeVec(logic st, logic iv, logic [15:0] d, logic ordy,
                                   logic [5:0] flags, logic [3:0] idx, logic [15:0] o);
    vec_t v;
    v.st = st; v.iv = iv; v.d = d; v.ordy = ordy; v.flags = flags; v.idx = idx; v.o = o;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start    = v.st;
    in_valid = v.iv;
    req_data = v.d;
    out_ready = v.ordy;
  endtask

  // Runs a whole frame from stim[0:nStim-1] with out_ready held high
  task automatic runFrame(input logic [7:0] w, input logic [7:0] h, input bit midStart);
    int idx;
    outs.delete();
    accCnt = 0; wenCnt = 0; clrCnt = 0; doneCnt = 0; idx = 0;
    out_ready = 1'b1;
    start = 1'b1; cfg_width = w; cfg_height = h; in_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 400 && doneCnt == 0; cyc++) begin
      in_valid = (idx < nStim);
      req_data = in_valid ? stim[idx] : 16'd0;
      if (midStart && cyc == 3) begin
        start = 1'b1; cfg_width = 8'd2; cfg_height = 8'd2;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin idx++; accCnt++; end
      if (pool_wen) wenCnt++;
      if (!pool_clr_n) clrCnt++;
      if (out_valid && out_ready) outs.push_back(out_data);
      if (done) doneCnt++;
      @(posedge clk); #1 start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input int expAcc, input int expWen, input int expClr);
    checkOutput({tag, "_done"}, doneCnt, 1);
    checkOutput({tag, "_outcount"}, outs.size(), expOut.size());
    for (int i = 0; i < expOut.size() && i < outs.size(); i++)
      checkOutput($sformatf("%s_out%0d", tag, i), {16'd0, outs[i]}, {16'd0, expOut[i]});
    checkOutput({tag, "_accepted"}, accCnt, expAcc);
    checkOutput({tag, "_wen"}, wenCnt, expWen);
    checkOutput({tag, "_clr"}, clrCnt, expClr);
  endtask

  task automatic tryBadStart(input string tag, input logic [7:0] w, input logic [7:0] h);
    start = 1'b1; cfg_width = w; cfg_height = h;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_err_busy"}, {30'd0, cfg_err, busy}, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, "_err_clear"}, {30'd0, cfg_err, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = makeVec(1, 0, 16'd0,    1, 6'b001000, 4'd0, 16'd0);
    vecs[1]  = makeVec(0, 1, 16'd1,    1, 6'b000010, 4'd0, 16'd0);
    vecs[2]  = makeVec(0, 1, 16'd1,    1, 6'b111010, 4'd0, 16'd0);
    vecs[3]  = makeVec(0, 1, 16'd5,    1, 6'b111010, 4'd0, 16'd0);
    vecs[4]  = makeVec(0, 0, 16'd0,    1, 6'b101010, 4'd1, 16'd0);
    vecs[5]  = makeVec(0, 1, 16'hFFFD, 1, 6'b111010, 4'd1, 16'd0);
    vecs[6]  = makeVec(0, 1, 16'd2,    1, 6'b111010, 4'd1, 16'd0);
    vecs[7]  = makeVec(0, 1, 16'd4,    1, 6'b111010, 4'd0, 16'd0);
    vecs[8]  = makeVec(0, 1, 16'd0,    1, 6'b101110, 4'd0, 16'd5);
    vecs[9]  = makeVec(0, 1, 16'hFFF9, 1, 6'b111010, 4'd1, 16'd0);
    vecs[10] = makeVec(0, 1, 16'hFFFF, 1, 6'b101110, 4'd1, 16'd2);
    vecs[11] = makeVec(0, 0, 16'd0,    1, 6'b001011, 4'd0, 16'd0);
    vecs[12] = makeVec(0, 0, 16'd0,    1, 6'b001000, 4'd0, 16'd0);

    // Reset values, with in_valid and out_ready up to show they are ignored
    in_valid = 1'b1;
    #2;
    checkOutput("reset_state",
                {24'd0, in_ready, pool_wen, pool_clr_n, out_valid, busy, done, cfg_err, 1'b0},
                {24'd0, 8'b00100000});
    checkOutput("reset_idx", {28'd0, pool_idx}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // W=4, H=2 frame, cycle by cycle
    cfg_width = 8'd4; cfg_height = 8'd2;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i),
                  {6'd0, in_ready, pool_wen, pool_clr_n, out_valid, busy, done, pool_idx,
                   (vecs[i].flags[2] ? out_data : 16'd0)},
                  {6'd0, vecs[i].flags, vecs[i].idx, vecs[i].o});
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // W=5, H=3 all ones: odd column and trailing row are consumed silently
    nStim = 15;
    for (int i = 0; i < 15; i++) stim[i] = 16'd1;
    expOut = '{16'd1, 16'd1};
    runFrame(8'd5, 8'd3, 1'b0);
    checkFrame("odd5x3", 15, 6, 1);

    // W=4, H=4: clearing between row pairs keeps 100 from leaking into -50 windows
    nStim = 16;
    for (int i = 0; i < 16; i++) stim[i] = (i < 8) ? 16'd100 : 16'hFFCE;
    expOut = '{16'd100, 16'd100, 16'hFFCE, 16'hFFCE};
    runFrame(8'd4, 8'd4, 1'b0);
    checkFrame("clear4x4", 16, 12, 2);

    // Widest map with a start pulse mid-frame that must be ignored
    nStim = 64;
    for (int i = 0; i < 64; i++) stim[i] = 16'(i % 32);
    expOut.delete();
    for (int k = 0; k < 16; k++) expOut.push_back(16'(2 * k + 1));
    runFrame(8'd32, 8'd2, 1'b1);
    checkFrame("wide32", 64, 48, 1);

    // Backpressure on the emitting pixel of a 2x2 frame
    start = 1'b1; cfg_width = 8'd2; cfg_height = 8'd2;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; req_data = 16'd7;
    @(posedge clk); #1 req_data = 16'hFFFE;
    @(posedge clk); #1 req_data = 16'd3;
    @(posedge clk); #1 req_data = 16'hFFFC; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_stall%0d", i),
                  {13'd0, in_ready, out_valid, pool_wen, 16'd0, out_data},
                  {13'd0, 3'b010, 16'd0, 16'd7});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", {14'd0, in_ready, out_valid, out_data}, {14'd0, 2'b11, 16'd7});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;

    // Rejected configurations
    tryBadStart("w1", 8'd1, 8'd4);
    tryBadStart("w34", 8'd34, 8'd4);
    tryBadStart("h1", 8'd4, 8'd1);

    // Asynchronous reset while sitting on an ODD-row emit pixel
    start = 1'b1; cfg_width = 8'd4; cfg_height = 8'd2;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; req_data = 16'd50;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    #1;
    checkOutput("pre_rst_emit", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_state",
                {24'd0, in_ready, pool_wen, pool_clr_n, out_valid, busy, done, cfg_err, 1'b0},
                {24'd0, 8'b00100000});
    checkOutput("mid_rst_idx", {28'd0, pool_idx}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    nStim = 8;
    for (int i = 0; i < 8; i++) stim[i] = 16'((i % 4) + 1);
    expOut = '{16'd2, 16'd4};
    runFrame(8'd4, 8'd2, 1'b0);
    checkFrame("post_rst", 8, 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
